burst_ram_slave: RTL



---
 rtl/burst_ram_slave.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/burst_ram_slave.sv
// burst_ram_slave: 4 KiB word RAM bus target answering single and burst
// reads/writes inside a 4 KiB address window. All bus outputs are registered
// and held at zero when idle so the interconnect can OR them together.
// Optional feature macro: BURST_RAM_ERROR_CHECK_EN (rejects bursts that would
// run past the last word, and writes with no byte lanes enabled).
module burst_ram_slave #(
    parameter logic [31:0] baseAddress = 32'h40000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        beginTransactionIn,
    input  logic        readNotWriteIn,
    input  logic [3:0]  byteEnablesIn,
    input  logic [7:0]  burstSizeIn,
    input  logic [31:0] addressDataIn,
    input  logic        dataValidIn,
    input  logic        endTransactionIn,
    output logic [31:0] addressDataOut,
    output logic        dataValidOut,
    output logic        endTransactionOut,
    output logic        busyOut,
    output logic        busErrorOut
);

    typedef enum logic [2:0] {
        IDLE, RD_FETCH, RD_BURST, RD_END, WR_SETUP, WR_DATA, ERR_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  idx_q, idx_d;      // word index, wraps naturally at 1023
    logic [8:0]  cnt_q, cnt_d;      // read: words left minus 1; write: words left
    logic [3:0]  be_q, be_d;
    logic [31:0] dout_q, dout_d;
    logic        dv_q, dv_d, eot_q, eot_d, busy_q, busy_d, err_q, err_d;
    logic [31:0] ram_q;
    logic [31:0] mem [1024];

    logic hit, reject, wr_en;

    assign hit = beginTransactionIn && (addressDataIn[31:12] == baseAddress[31:12]);

`ifdef BURST_RAM_ERROR_CHECK_EN
    // Reject bursts that cross the top of the RAM and writes with no lanes.
    assign reject = hit && ((({1'b0, addressDataIn[11:2]} + {3'b000, burstSizeIn}) > 11'd1023)
                            || (!readNotWriteIn && byteEnablesIn == 4'h0));
`else
    assign reject = 1'b0;
`endif

    assign wr_en = (state_q == WR_DATA) && dataValidIn && !busy_q && (cnt_q != 9'd0);

    // Next-state logic and next values of the registered bus outputs.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        be_d    = be_q;
        dout_d  = '0;
        dv_d    = 1'b0;
        eot_d   = 1'b0;
        busy_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    idx_d = addressDataIn[11:2];
                    be_d  = byteEnablesIn;
                    if (reject) begin
                        err_d   = 1'b1;
                        state_d = readNotWriteIn ? RD_END : ERR_WAIT;
                    end else if (readNotWriteIn) begin
                        cnt_d   = {1'b0, burstSizeIn};
                        state_d = RD_FETCH;
                    end else begin
                        cnt_d   = {1'b0, burstSizeIn} + 9'd1;
                        busy_d  = 1'b1;
                        state_d = WR_SETUP;
                    end
                end
            end
            RD_FETCH: begin
                // RAM register captures the first word on this edge.
                idx_d   = idx_q + 10'd1;
                state_d = RD_BURST;
            end
            RD_BURST: begin
                dout_d = ram_q;
                dv_d   = 1'b1;
                if (cnt_q == 9'd0) begin
                    state_d = RD_END;
                end else begin
                    idx_d = idx_q + 10'd1;
                    cnt_d = cnt_q - 9'd1;
                end
            end
            RD_END: begin
                eot_d   = 1'b1;
                state_d = IDLE;
            end
            WR_SETUP: state_d = WR_DATA;
            WR_DATA: begin
                if (wr_en) begin
                    idx_d = idx_q + 10'd1;
                    cnt_d = cnt_q - 9'd1;
                end
                if (endTransactionIn) state_d = IDLE;
            end
            ERR_WAIT: if (endTransactionIn) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Control state and output registers; reset clears outputs immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            be_q    <= '0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            eot_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            be_q    <= be_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            eot_q   <= eot_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Word RAM with per-lane writes and a synchronous read port; not reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) mem[idx_q][8*b +: 8] <= addressDataIn[8*b +: 8];
            end
        end
        ram_q <= mem[idx_q];
    end

    assign addressDataOut    = dout_q;
    assign dataValidOut      = dv_q;
    assign endTransactionOut = eot_q;
    assign busyOut           = busy_q;
    assign busErrorOut       = err_q;

endmodule
